// File: rtl/ord_tx_framer.sv
// Order transmit framer: buffers 128-bit orders, rate-limits them with a token bucket and
// serialises each into a 5-beat, 32-bit packet (header with sequence number + 4 payload beats).
module ord_tx_framer #(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned TOKEN_MAX    = 8,
   parameter int unsigned TOKEN_PERIOD = 256
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         ord_valid,
   input  logic [127:0] ord_data,
   output logic         ord_ready,
   output logic         tx_valid,
   input  logic         tx_ready,
   output logic [31:0]  tx_data,
   output logic         tx_sop,
   output logic         tx_eop,
   output logic [1:0]   tx_empty,
   output logic [15:0]  drop_cnt,
   output logic [7:0]   tokens
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned RW = $clog2(TOKEN_PERIOD);

   typedef enum logic [1:0] {StIdle, StHdr, StPay} state_e;

   logic [127:0]  mem [FIFO_DEPTH];
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [RW-1:0] rcnt_q, rcnt_d;
   logic [7:0]    tokens_d;
   logic [15:0]   drop_d;
   state_e        state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   seq_q, seq_d;
   logic [127:0]  hold_q, hold_d;
   logic          tx_valid_d, tx_sop_d, tx_eop_d;
   logic [31:0]   tx_data_d;
   logic          full, empty, pop, push, drop, wrap;

   assign tx_empty = 2'b00;
   assign full     = (count_q == CW'(FIFO_DEPTH));
   assign empty    = (count_q == '0);
   assign pop      = (state_q == StIdle) && !empty && (tokens != 8'd0);
   // A pop in the same cycle frees a slot, so a push against a full buffer still lands.
   assign push     = ord_valid && (!full || pop);
   assign drop     = ord_valid && full && !pop;
   assign wrap     = (rcnt_q == RW'(TOKEN_PERIOD - 1));

   // Buffer, bucket and drop-counter next-state.
   always_comb begin
      wptr_d   = push ? wptr_q + AW'(1) : wptr_q;
      rptr_d   = pop ? rptr_q + AW'(1) : rptr_q;
      count_d  = count_q;
      if (push && !pop) count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      rcnt_d   = wrap ? '0 : rcnt_q + RW'(1);
      tokens_d = tokens;
      if (pop && !wrap) tokens_d = tokens - 8'd1;
      else if (!pop && wrap && (tokens < 8'(TOKEN_MAX))) tokens_d = tokens + 8'd1;
      drop_d   = (drop && (drop_cnt != 16'hFFFF)) ? drop_cnt + 16'd1 : drop_cnt;
   end

   // Order storage; contents need no reset since the pointers define validity.
   always_ff @(posedge clk) begin
      if (reset_n && push) mem[wptr_q] <= ord_data;
   end

   // State register: FSM, buffer pointers, bucket and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         idx_q     <= 2'd0;
         seq_q     <= 16'd0;
         hold_q    <= '0;
         wptr_q    <= '0;
         rptr_q    <= '0;
         count_q   <= '0;
         rcnt_q    <= '0;
         tokens    <= 8'(TOKEN_MAX);
         drop_cnt  <= 16'd0;
         ord_ready <= 1'b1;
         tx_valid  <= 1'b0;
         tx_sop    <= 1'b0;
         tx_eop    <= 1'b0;
         tx_data   <= 32'd0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         seq_q     <= seq_d;
         hold_q    <= hold_d;
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         count_q   <= count_d;
         rcnt_q    <= rcnt_d;
         tokens    <= tokens_d;
         drop_cnt  <= drop_d;
         ord_ready <= (count_d != CW'(FIFO_DEPTH));
         tx_valid  <= tx_valid_d;
         tx_sop    <= tx_sop_d;
         tx_eop    <= tx_eop_d;
         tx_data   <= tx_data_d;
      end
   end

   // FSM next-state: advance only on an accepted beat.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      seq_d   = seq_q;
      hold_d  = hold_q;
      unique case (state_q)
         StIdle: begin
            if (pop) begin
               hold_d  = mem[rptr_q];
               state_d = StHdr;
            end
         end
         StHdr: begin
            if (tx_ready) begin
               state_d = StPay;
               idx_d   = 2'd0;
            end
         end
         StPay: begin
            if (tx_ready) begin
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = StIdle;
                  seq_d   = seq_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output decode from next state so the beat is registered and stable until accepted.
   always_comb begin
      tx_valid_d = (state_d != StIdle);
      tx_sop_d   = (state_d == StHdr);
      tx_eop_d   = (state_d == StPay) && (idx_d == 2'd3);
      tx_data_d  = 32'd0;
      if (state_d == StHdr) begin
         tx_data_d = {seq_d, 16'h0010};
      end else if (state_d == StPay) begin
         unique case (idx_d)
            2'd0: tx_data_d = hold_d[127:96];
            2'd1: tx_data_d = hold_d[95:64];
            2'd2: tx_data_d = hold_d[63:32];
            2'd3: tx_data_d = hold_d[31:0];
            default: tx_data_d = 32'd0;
         endcase
      end
   end

endmodule
